// File: rtl/axi_slave_mem_pkg.sv
// axi_slave_mem_pkg: shared AXI widths, field types and FSM state encodings
package axi_slave_mem_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
endpackage

// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI4 channel bundle between a master and the slave memory
interface axi_slave_mem_if;
    import axi_slave_mem_pkg::*;
    addr_t  araddr;
    len_t   arlen;
    size_t  arsize;
    burst_t arburst;
    logic   arvalid;
    logic   arready;
    data_t  rdata;
    resp_t  rresp;
    logic   rlast;
    logic   rvalid;
    logic   rready;
    addr_t  awaddr;
    len_t   awlen;
    size_t  awsize;
    burst_t awburst;
    logic   awvalid;
    logic   awready;
    data_t  wdata;
    strb_t  wstrb;
    logic   wlast;
    logic   wvalid;
    logic   wready;
    resp_t  bresp;
    logic   bvalid;
    logic   bready;
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP plus size/wrap-length legality
module axi_burst_addr_gen
    import axi_slave_mem_pkg::*;
(
    input  addr_t      addr,
    input  len_t       len,
    input  size_t      size,
    input  logic [1:0] burst,
    output addr_t      next_addr,
    output logic       err
);
    addr_t bytes, incr, total, boundary;
    // Align to the beat size, step one beat, and fold back at the wrap boundary
    always_comb begin
        bytes     = addr_t'(1) << size;
        incr      = (addr & ~(bytes - addr_t'(1))) + bytes;
        total     = (addr_t'(len) + addr_t'(1)) << size;
        boundary  = addr & ~(total - addr_t'(1));
        next_addr = burst == FIXED ? addr : (burst == WRAP && incr == boundary + total) ? boundary : incr;
        err       = size > 3'd2 || (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave memory with independent read and write burst engines
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input logic aclk,
    input logic areset,
    axi_slave_mem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    data_t mem [MEM_DEPTH];

    logic [0:0] r_state;
    addr_t      r_addr;
    len_t       r_len, r_cnt;
    size_t      r_size;
    burst_t     r_burst;
    logic       arready, rvalid, rlast;
    data_t      rdata;
    resp_t      rresp;
    addr_t      rg_addr, rg_next, r_load_addr;
    len_t       rg_len;
    size_t      rg_size;
    logic [1:0] rg_burst;
    logic       rg_err, r_load_ok;
    data_t      r_load_data;

    logic [1:0] w_state;
    addr_t      w_addr;
    len_t       w_len, w_cnt;
    size_t      w_size;
    burst_t     w_burst;
    logic       w_err, awready, wready, bvalid;
    resp_t      bresp;
    addr_t      wg_next;
    logic       wg_err, w_beat, w_beat_err;

    function automatic logic in_range(addr_t a);
        return (a >> 2) < addr_t'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word(addr_t a);
        return IDX_W'(a >> 2);
    endfunction

    // While idle the read generator sees the incoming AR fields so the first beat's legality is known at the handshake
    assign rg_addr     = r_state == R_IDLE ? bus.araddr : r_addr;
    assign rg_len      = r_state == R_IDLE ? bus.arlen : r_len;
    assign rg_size     = r_state == R_IDLE ? bus.arsize : r_size;
    assign rg_burst    = r_state == R_IDLE ? bus.arburst : r_burst;
    assign r_load_addr = r_state == R_IDLE ? bus.araddr : rg_next;
    assign r_load_ok   = !rg_err && in_range(r_load_addr);
    assign r_load_data = in_range(r_load_addr) ? mem[word(r_load_addr)] : '0;

    axi_burst_addr_gen u_rd_gen (
        .addr      (rg_addr),
        .len       (rg_len),
        .size      (rg_size),
        .burst     (rg_burst),
        .next_addr (rg_next),
        .err       (rg_err)
    );

    axi_burst_addr_gen u_wr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (wg_next),
        .err       (wg_err)
    );

    assign w_beat     = wready && bus.wvalid;
    assign w_beat_err = wg_err || !in_range(w_addr) || (bus.wlast != (w_cnt == w_len));

    // Read engine: load a beat at the AR handshake, then one more per accepted non-last beat
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= FIXED;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else if (r_state == R_IDLE) begin
            arready <= !(arready && bus.arvalid);
            if (arready && bus.arvalid) begin
                r_state <= R_DATA;
                r_addr  <= bus.araddr;
                r_len   <= bus.arlen;
                r_size  <= bus.arsize;
                r_burst <= bus.arburst;
                r_cnt   <= '0;
                rvalid  <= 1'b1;
                rlast   <= bus.arlen == 8'd0;
                rdata   <= r_load_data;
                rresp   <= r_load_ok ? OKAY : SLVERR;
            end
        end else if (rvalid && bus.rready) begin
            if (rlast) begin
                r_state <= R_IDLE;
                arready <= 1'b1;
                rvalid  <= 1'b0;
                rlast   <= 1'b0;
            end else begin
                r_addr <= rg_next;
                r_cnt  <= r_cnt + 8'd1;
                rlast  <= r_cnt + 8'd1 == r_len;
                rdata  <= r_load_data;
                rresp  <= r_load_ok ? OKAY : SLVERR;
            end
        end

    // Write engine: accept the address, take len+1 beats accumulating a sticky error, then respond
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= FIXED;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else if (w_state == W_IDLE) begin
            awready <= !(awready && bus.awvalid);
            if (awready && bus.awvalid) begin
                w_state <= W_DATA;
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_size  <= bus.awsize;
                w_burst <= bus.awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
                wready  <= 1'b1;
            end
        end else if (w_state == W_DATA) begin
            if (w_beat) begin
                w_addr <= wg_next;
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err || w_beat_err;
                if (w_cnt == w_len) begin
                    w_state <= W_RESP;
                    wready  <= 1'b0;
                    bvalid  <= 1'b1;
                    bresp   <= (w_err || w_beat_err) ? SLVERR : OKAY;
                end
            end
        end else if (bus.bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
        end

    // Storage is deliberately left out of reset; an illegal burst shape suppresses every lane
    always_ff @(posedge aclk)
        if (w_beat && !wg_err && in_range(w_addr))
            for (int i = 0; i < STRB_WIDTH; i++)
                if (bus.wstrb[i]) mem[word(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];

    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rlast   = rlast;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized scoreboard bench for the AXI4 slave memory
module tb_axi_slave_mem;
    import axi_slave_mem_pkg::*;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rexp_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    axi_slave_mem_if bus();

    axi_slave_mem #(.MEM_DEPTH(DEPTH)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    logic [31:0] m [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    rexp_t       rq [$];
    logic [1:0]  bq [$];
    bit          rr_pat [$];
    bit          rr_rand = 1'b0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        bus.rready = rr_pat.size() != 0 ? rr_pat.pop_front() : rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.bready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic hs(input int k);
        int t;
        logic ok;
        t = 0;
        do begin
            @(negedge aclk);
            ok = k == 0 ? bus.awready : k == 1 ? bus.wready : bus.arready;
            tick();
            t++;
        end while (!ok && t < 50);
        if (!ok) fail_now(k == 0 ? "aw_handshake" : k == 1 ? "w_handshake" : "ar_handshake");
    endtask

    function automatic int unsigned baddr(int unsigned a, int size, int burst, int len, int n);
        int unsigned b, tot, base;
        b = 1 << size;
        if (burst == 0 || n == 0) return a;
        if (burst == 1) return a / b * b + n * b;
        tot = b * (len + 1);
        base = a / tot * tot;
        return base + (a - base + n * b) % tot;
    endfunction

    function automatic bit bad_shape(int size, int burst, int len);
        return size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15}));
    endfunction

    task automatic do_write(input int unsigned a, input int len, input int size, input int burst, input int last_at);
        int unsigned ba, w;
        bit bad, err;
        int t;
        bad = bad_shape(size, burst, len);
        err = bad;
        for (int i = 0; i <= len; i++) begin
            ba = baddr(a, size, burst, len, i);
            w = ba >> 2;
            if (w >= DEPTH) err = 1'b1;
            else if (!bad)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) m[w][8*b +: 8] = wd[i][8*b +: 8];
            if ((i == last_at) != (i == len)) err = 1'b1;
        end
        bq.push_back(err ? 2'b10 : 2'b00);
        bus.awaddr = a;
        bus.awlen = 8'(len);
        bus.awsize = 3'(size);
        bus.awburst = burst_t'(2'(burst));
        bus.awvalid = 1'b1;
        hs(0);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata = wd[i];
            bus.wstrb = ws[i];
            bus.wlast = i == last_at;
            bus.wvalid = 1'b1;
            hs(1);
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        t = 0;
        while (bq.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (bq.size() != 0) begin
            fail_now("b_response");
            bq.delete();
        end
    endtask

    task automatic do_read(input int unsigned a, input int len, input int size, input int burst, input bit pat);
        int unsigned ba, w;
        bit bad;
        rexp_t e;
        int t;
        bad = bad_shape(size, burst, len);
        for (int n = 0; n <= len; n++) begin
            ba = baddr(a, size, burst, len, n);
            w = ba >> 2;
            e.d = w >= DEPTH ? 32'h0 : m[w];
            e.r = (w >= DEPTH || bad) ? 2'b10 : 2'b00;
            e.l = n == len;
            rq.push_back(e);
        end
        bus.araddr = a;
        bus.arlen = 8'(len);
        bus.arsize = 3'(size);
        bus.arburst = burst_t'(2'(burst));
        bus.arvalid = 1'b1;
        hs(2);
        bus.arvalid = 1'b0;
        chk("rvalid_after_ar", 64'(bus.rvalid), 64'(1));
        if (pat) rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        t = 0;
        while (rq.size() != 0 && t < 400) begin
            tick();
            t++;
        end
        if (rq.size() != 0) begin
            fail_now("r_burst");
            rq.delete();
        end
    endtask

    // Monitor: every presented R or B beat is compared against the front of its queue and popped on acceptance
    always @(negedge aclk)
        if (!areset) begin
            if (bus.rvalid) begin
                if (rq.size() == 0) begin
                    total++;
                    $display("FAIL r_unexpected: got rdata %0h with no beat expected", bus.rdata);
                end else begin
                    chk("rdata", 64'(bus.rdata), 64'(rq[0].d));
                    chk("rresp", 64'(bus.rresp), 64'(rq[0].r));
                    chk("rlast", 64'(bus.rlast), 64'(rq[0].l));
                    if (bus.rready) void'(rq.pop_front());
                end
            end
            if (bus.bvalid) begin
                if (bq.size() == 0) begin
                    total++;
                    $display("FAIL b_unexpected: got bresp %0h with no response expected", bus.bresp);
                end else begin
                    chk("bresp", 64'(bus.bresp), 64'(bq[0]));
                    if (bus.bready) void'(bq.pop_front());
                end
            end
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sz, bt, ln, a, tot, la;
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        bus.araddr = '0;
        bus.arlen = '0;
        bus.arsize = '0;
        bus.arburst = FIXED;
        bus.awaddr = '0;
        bus.awlen = '0;
        bus.awsize = '0;
        bus.awburst = FIXED;
        bus.wdata = '0;
        bus.wstrb = '0;
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        tick();
        tick();
        chk("reset_arready", 64'(bus.arready), 64'(0));
        chk("reset_awready", 64'(bus.awready), 64'(0));
        chk("reset_wready", 64'(bus.wready), 64'(0));
        chk("reset_rvalid", 64'(bus.rvalid), 64'(0));
        chk("reset_bvalid", 64'(bus.bvalid), 64'(0));
        chk("reset_rdata", 64'(bus.rdata), 64'(0));
        areset = 1'b0;
        tick();
        chk("post_reset_arready", 64'(bus.arready), 64'(1));
        chk("post_reset_awready", 64'(bus.awready), 64'(1));

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'hF;
            end
            do_write(b * 1024, 255, 2, 1, 255);
        end

        wd[0] = 32'hDEADBEEF;
        ws[0] = 4'hF;
        do_write(32'h10, 0, 2, 1, 0);
        do_read(32'h10, 0, 2, 1, 0);

        for (int i = 0; i < 4; i++) begin
            wd[i] = i + 1;
            ws[i] = 4'hF;
        end
        do_write(32'h20, 3, 2, 1, 3);
        do_read(32'h20, 3, 2, 1, 0);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA + i;
            ws[i] = 4'hF;
        end
        do_write(32'h38, 3, 2, 2, 3);
        do_read(32'h30, 3, 2, 1, 0);

        wd[0] = 32'hFFFFFFFF;
        ws[0] = 4'hF;
        do_write(32'h40, 0, 2, 1, 0);
        wd[0] = 32'h11223344;
        ws[0] = 4'h5;
        do_write(32'h40, 0, 2, 1, 0);
        do_read(32'h40, 0, 2, 1, 0);

        wd[0] = 32'h55AA55AA;
        ws[0] = 4'hF;
        do_write(DEPTH * 4, 0, 2, 1, 0);
        do_read(DEPTH * 4, 0, 2, 1, 0);
        do_read((DEPTH - 1) * 4, 2, 2, 1, 0);

        do_read(32'h20, 2, 2, 1, 1);

        for (int i = 0; i < 3; i++) begin
            wd[i] = 32'h5000 + i;
            ws[i] = 4'hF;
        end
        do_write(32'h50, 2, 2, 1, 1);
        do_read(32'h50, 2, 2, 1, 0);

        for (int i = 0; i < 3; i++) wd[i] = 32'hBAD0 + i;
        do_write(32'h60, 1, 3, 1, 1);
        do_write(32'h60, 2, 2, 2, 2);
        do_read(32'h60, 3, 2, 1, 0);

        bus.araddr = 32'h20;
        bus.arlen = 8'd3;
        bus.arsize = 3'd2;
        bus.arburst = INCR;
        for (int n = 0; n < 4; n++) rq.push_back('{m[8 + n], 2'b00, n == 3});
        bus.arvalid = 1'b1;
        hs(2);
        bus.arvalid = 1'b0;
        tick();
        areset = 1'b1;
        #1;
        chk("mid_reset_rvalid", 64'(bus.rvalid), 64'(0));
        chk("mid_reset_rlast", 64'(bus.rlast), 64'(0));
        chk("mid_reset_rdata", 64'(bus.rdata), 64'(0));
        chk("mid_reset_arready", 64'(bus.arready), 64'(0));
        rq.delete();
        tick();
        tick();
        areset = 1'b0;
        tick();
        chk("release_arready", 64'(bus.arready), 64'(1));
        chk("release_awready", 64'(bus.awready), 64'(1));
        do_read(32'h20, 3, 2, 1, 0);
        do_read(32'h38, 3, 2, 2, 0);

        rr_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            sz = $urandom_range(0, 2);
            bt = $urandom_range(0, 2);
            ln = bt == 2 ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 7);
            a = ($urandom_range(0, 3) == 0 ? $urandom_range(DEPTH - 4, DEPTH + 2) : $urandom_range(0, 63)) * 4 + $urandom_range(0, 3);
            if (bt == 2) begin
                tot = (1 << sz) * (ln + 1);
                a = a / tot * tot;
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= int'(ln); i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom);
                end
                la = $urandom_range(0, 7) == 0 ? $urandom_range(0, ln) : ln;
                do_write(a, ln, sz, bt, la);
            end else do_read(a, ln, sz, bt, 0);
        end

        chk("r_queue_drained", 64'(rq.size()), 64'(0));
        chk("b_queue_drained", 64'(bq.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
